// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg -- shared types for the RV32I instruction-fetch stage.
//   PKG_XLEN      : datapath width the IF/ID payload is built for
//   NOP_INST      : canonical NOP (addi x0,x0,0) shown in every empty IF/ID slot
//   fetch_state_e : FETCH (request outstanding), HOLD (word parked, stalled),
//                   DRAIN (stale request being waited out after a flush)
//   if_id_t       : IF/ID register payload {inst, pc, pc4, valid}
//   align_word()  : clears bits [1:0] of a redirect address
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int unsigned PKG_XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]         inst;
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] pc4;
    logic                valid;
  } if_id_t;

  function automatic logic [PKG_XLEN-1:0] align_word(input logic [PKG_XLEN-1:0] addr);
    return addr & {{(PKG_XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if -- instruction-memory request/response bus.
//   imem_req_o   : fetch request, held until the response strobe
//   imem_addr_o  : fetch address, stable while imem_req_o=1
//   imem_valid_i : response strobe for the outstanding request
//   imem_rdata_i : instruction word, qualified by imem_valid_i
// master = fetch stage side, slave = instruction memory side.
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_valid_i;
  logic [31:0]     imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_valid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_valid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg -- IF/ID pipeline register.
//   clk, rst_n   : clock, synchronous active-low reset
//   load_i       : capture load_data_i
//   squash_i     : invalidate the slot (wins over load_i)
//   load_data_i  : new IF/ID payload
//   ifid_o       : registered IF/ID payload
// With neither control asserted the slot holds. A squashed slot always shows
// NOP_INST so decode never sees a stale opcode.
// -----------------------------------------------------------------------------
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   squash_i,
  input  if_id_t load_data_i,
  output if_id_t ifid_o
);

  if_id_t ifid_q;
  if_id_t ifid_d;

  // Select squash / load / hold for the next IF/ID contents.
  always_comb begin
    ifid_d = ifid_q;
    if (squash_i) begin
      ifid_d.valid = 1'b0;
      ifid_d.inst  = NOP_INST;
    end else if (load_i) begin
      ifid_d = load_data_i;
    end else begin
      ifid_d = ifid_q;
    end
  end

  // IF/ID register with synchronous reset to an empty NOP slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_q.inst  <= NOP_INST;
      ifid_q.pc    <= {PKG_XLEN{1'b0}};
      ifid_q.pc4   <= {PKG_XLEN{1'b0}};
      ifid_q.valid <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- RV32I instruction-fetch stage. Owns the PC, keeps one
// request outstanding to instruction memory and fills the IF/ID register.
//   clk, rst_n    : clock, synchronous active-low reset
//   stall_i       : hold IF/ID and PC (load-use hazard)
//   flush_i       : squash IF/ID, redirect PC to br_target_i (bits [1:0] dropped)
//   imem          : instruction-memory bus (fetch_stage_if.master)
//   ifid_*_o      : IF/ID instruction, PC, PC+4 and valid
// Optional macro FETCH_PERF_EN adds perf_fetched_o / perf_bubble_o counters.
// Priority: reset > flush > stall. XLEN must match riscv_pkg::PKG_XLEN.
// -----------------------------------------------------------------------------
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = PKG_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] br_target_i,
  fetch_stage_if.master   imem,
  output logic [31:0]     ifid_inst_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic            ifid_valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_bubble_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [31:0]     skid_q, skid_d;
  logic            req_q, req_d;

  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] redirect_s;
  logic            rsp_s;
  logic            load_s;
  logic            squash_s;
  if_id_t          ld_data_s;
  if_id_t          ifid_s;

  // Wraps modulo 2^XLEN by construction.
  assign pc_plus4_s = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
  assign redirect_s = align_word(br_target_i);
  // A response only counts while our own request is up; this drops late
  // strobes belonging to a request abandoned by reset.
  assign rsp_s      = imem.imem_valid_i & req_q;

  // State register: FSM state, PC, saved flush target, skid word, request flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= {XLEN{1'b0}};
      skid_q  <= NOP_INST;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      skid_q  <= skid_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic: state transitions, PC update, skid and saved target.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    skid_d  = skid_q;
    case (state_q)
      FETCH: begin
        if (rsp_s) begin
          if (flush_i) begin
            pc_d = redirect_s;
          end else if (stall_i) begin
            skid_d  = imem.imem_rdata_i;
            state_d = HOLD;
          end else begin
            pc_d = pc_plus4_s;
          end
        end else if (flush_i) begin
          if (req_q) begin
            // The outstanding request cannot be withdrawn: wait it out.
            tgt_d   = redirect_s;
            state_d = DRAIN;
          end else begin
            // Nothing in flight yet (first cycle after reset): redirect now.
            pc_d = redirect_s;
          end
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (flush_i) begin
          pc_d    = redirect_s;
          state_d = FETCH;
        end else if (!stall_i) begin
          pc_d    = pc_plus4_s;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (rsp_s) begin
          // A flush arriving with the stale word still has the final say.
          pc_d    = flush_i ? redirect_s : tgt_q;
          state_d = FETCH;
        end else if (flush_i) begin
          tgt_d = redirect_s;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Output logic: IF/ID load/squash controls and the next request flag.
  always_comb begin
    load_s          = 1'b0;
    squash_s        = 1'b0;
    ld_data_s.inst  = imem.imem_rdata_i;
    ld_data_s.pc    = pc_q;
    ld_data_s.pc4   = pc_plus4_s;
    ld_data_s.valid = 1'b1;
    case (state_q)
      FETCH: begin
        if (flush_i) begin
          squash_s = 1'b1;
        end else if (stall_i) begin
          load_s = 1'b0;
        end else if (rsp_s) begin
          load_s = 1'b1;
        end else begin
          squash_s = 1'b1;
        end
      end
      HOLD: begin
        ld_data_s.inst = skid_q;
        if (flush_i) begin
          squash_s = 1'b1;
        end else if (!stall_i) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      DRAIN: begin
        squash_s = 1'b1;
      end
      default: begin
        squash_s = 1'b1;
      end
    endcase
    // Memory is idle only while a word sits parked in the skid.
    req_d = (state_d != HOLD);
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_s),
    .squash_i    (squash_s),
    .load_data_i (ld_data_s),
    .ifid_o      (ifid_s)
  );

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = pc_q;

  assign ifid_inst_o  = ifid_s.valid ? ifid_s.inst : NOP_INST;
  assign ifid_pc_o    = ifid_s.pc;
  assign ifid_pc4_o   = ifid_s.pc4;
  assign ifid_valid_o = ifid_s.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  // Count delivered instructions and non-stall bubbles; both wrap.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubble_d  = perf_bubble_q;
    if (load_s) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end else begin
      perf_fetched_d = perf_fetched_q;
    end
    if (squash_s) begin
      perf_bubble_d = perf_bubble_q + 32'd1;
    end else begin
      perf_bubble_d = perf_bubble_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_bubble_q  <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubble_q  <= perf_bubble_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_bubble_o  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage.
// A behavioural instruction memory answers each request after a chosen or
// random latency with word = (addr << 12) | 0x93. Directed scenarios check
// exact cycles; the random scenario checks the delivered instruction stream
// against a program-order model (sequential +4, redirect on flush).
// A second instance with RESET_PC=0xFFFF_FFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] WRAPPC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush;
  logic [31:0] tgt;
  logic [31:0] ifid_inst, ifid_pc, ifid_pc4;
  logic        ifid_valid;
  logic [31:0] w_inst, w_pc, w_pc4;
  logic        w_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model controls
  logic        mem_auto, mem_rand;
  int          mem_lat;
  logic        man_valid;
  logic [31:0] man_rdata;
  logic        auto_valid;
  logic [31:0] auto_rdata;
  logic        busy;
  int          cnt;
  logic [31:0] laddr;

  fetch_stage_if #(.XLEN(32)) mif ();
  fetch_stage_if #(.XLEN(32)) wif ();

  assign mif.imem_valid_i = mem_auto ? auto_valid : man_valid;
  assign mif.imem_rdata_i = mem_auto ? auto_rdata : man_rdata;
  assign wif.imem_valid_i = 1'b1;
  assign wif.imem_rdata_i = 32'h0000_0113;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_f, perf_b, w_perf_f, w_perf_b;
`endif

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush), .br_target_i(tgt),
    .imem(mif.master),
    .ifid_inst_o(ifid_inst), .ifid_pc_o(ifid_pc), .ifid_pc4_o(ifid_pc4), .ifid_valid_o(ifid_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched_o(perf_f), .perf_bubble_o(perf_b)
`endif
  );

  fetch_stage #(.XLEN(32), .RESET_PC(WRAPPC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .flush_i(1'b0), .br_target_i(32'h0000_0000),
    .imem(wif.master),
    .ifid_inst_o(w_inst), .ifid_pc_o(w_pc), .ifid_pc4_o(w_pc4), .ifid_valid_o(w_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched_o(w_perf_f), .perf_bubble_o(w_perf_b)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 12) | 32'h0000_0093;
  endfunction

  // Behavioural instruction memory, acting on the falling edge.
  initial begin
    busy = 1'b0; cnt = 0; laddr = 32'h0; auto_valid = 1'b0; auto_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!mem_auto) begin
        busy = 1'b0;
        auto_valid = 1'b0;
      end else begin
        if (auto_valid) begin
          auto_valid = 1'b0;
          busy = 1'b0;
        end
        if (busy) begin
          n_cmp++;
          if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== laddr) begin
            n_bad++;
            $display("FAIL addr_stable: req=%0b addr=%h, required req=1 addr=%h",
                     mif.imem_req_o, mif.imem_addr_o, laddr);
          end
        end
        if (mif.imem_req_o === 1'b1 && !busy) begin
          busy  = 1'b1;
          laddr = mif.imem_addr_o;
          cnt   = mem_rand ? int'($urandom_range(3, 1)) : mem_lat;
        end
        if (busy && !auto_valid) begin
          cnt--;
          if (cnt == 0) begin
            auto_valid = 1'b1;
            auto_rdata = mem_word(laddr);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    mem_auto = 1'b0; man_valid = 1'b0; stall = 1'b0; flush = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1; mem_auto = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    mem_lat = 1; mem_rand = 1'b0;
    do_reset();
    n_cmp++; if (mif.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %0b want 0", mif.imem_req_o); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", ifid_valid); end
    n_cmp++; if (ifid_inst !== NOP) begin n_bad++; $display("FAIL rst_inst: got %h want %h", ifid_inst, NOP); end
    n_cmp++; if (ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h/%h want 0/0", ifid_pc, ifid_pc4); end
    release_reset();
    n_cmp++; if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL first_req: got req=%0b addr=%h want 1/0", mif.imem_req_o, mif.imem_addr_o); end
  endtask

  task automatic test_back_to_back();
    mem_lat = 1; mem_rand = 1'b0;
    do_reset(); release_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 32'(4*i) || ifid_inst !== mem_word(32'(4*i)) || ifid_pc4 !== 32'(4*i+4)) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got v=%0b pc=%h inst=%h pc4=%h want v=1 pc=%h inst=%h pc4=%h", i,
                 ifid_valid, ifid_pc, ifid_inst, ifid_pc4, 32'(4*i), mem_word(32'(4*i)), 32'(4*i+4));
      end
    end
  endtask

  task automatic test_stall();
    mem_lat = 1; mem_rand = 1'b0;
    do_reset(); release_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4 || mif.imem_req_o !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got v=%0b pc=%h req=%0b want v=1 pc=4 req=0", k, ifid_valid, ifid_pc, mif.imem_req_o);
      end
    end
    @(negedge clk); stall = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_inst !== mem_word(32'h8)) begin
      n_bad++; $display("FAIL stall_release: got v=%0b pc=%h inst=%h want v=1 pc=8 inst=%h", ifid_valid, ifid_pc, ifid_inst, mem_word(32'h8));
    end
    n_cmp++;
    if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'hC) begin
      n_bad++; $display("FAIL no_refetch: got req=%0b addr=%h want 1/c", mif.imem_req_o, mif.imem_addr_o);
    end
  endtask

  task automatic test_flush_drain();
    mem_lat = 4; mem_rand = 1'b0;
    do_reset(); release_reset();
    @(negedge clk); flush = 1'b1; tgt = 32'h0000_0100;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h0 || ifid_valid !== 1'b0) begin
        n_bad++; $display("FAIL drain[%0d]: got req=%0b addr=%h v=%0b want 1/0/0", k, mif.imem_req_o, mif.imem_addr_o, ifid_valid);
      end
      if (k == 0) begin
        @(negedge clk); flush = 1'b0;
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h100 || ifid_valid !== 1'b0) begin
      n_bad++; $display("FAIL drain_redirect: got req=%0b addr=%h v=%0b want 1/100/0", mif.imem_req_o, mif.imem_addr_o, ifid_valid);
    end
    mem_lat = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100 || ifid_inst !== mem_word(32'h100)) begin
      n_bad++; $display("FAIL drain_target: got v=%0b pc=%h inst=%h want v=1 pc=100 inst=%h", ifid_valid, ifid_pc, ifid_inst, mem_word(32'h100));
    end
  endtask

  task automatic test_flush_stall();
    mem_lat = 1; mem_rand = 1'b0;
    do_reset(); release_reset();
    @(negedge clk); flush = 1'b1; stall = 1'b1; tgt = 32'h0000_0203;
    @(posedge clk); #1;
    n_cmp++;
    if (ifid_valid !== 1'b0 || ifid_inst !== NOP) begin
      n_bad++; $display("FAIL fs_squash: got v=%0b inst=%h want v=0 inst=%h", ifid_valid, ifid_inst, NOP);
    end
    n_cmp++;
    if (mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h200) begin
      n_bad++; $display("FAIL fs_addr: got req=%0b addr=%h want 1/200", mif.imem_req_o, mif.imem_addr_o);
    end
    @(negedge clk); flush = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || ifid_inst !== mem_word(32'h200)) begin
      n_bad++; $display("FAIL fs_target: got v=%0b pc=%h inst=%h want v=1 pc=200", ifid_valid, ifid_pc, ifid_inst);
    end
  endtask

  task automatic test_wrap();
    mem_lat = 1; mem_rand = 1'b0;
    do_reset(); release_reset();
    n_cmp++;
    if (wif.imem_req_o !== 1'b1 || wif.imem_addr_o !== WRAPPC) begin
      n_bad++; $display("FAIL wrap_first: got req=%0b addr=%h want 1/%h", wif.imem_req_o, wif.imem_addr_o, WRAPPC);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (w_valid !== 1'b1 || w_pc !== WRAPPC || w_pc4 !== 32'h0 || w_inst !== 32'h0000_0113) begin
      n_bad++; $display("FAIL wrap_ifid: got v=%0b pc=%h pc4=%h inst=%h want 1/%h/0/113", w_valid, w_pc, w_pc4, w_inst, WRAPPC);
    end
    n_cmp++;
    if (wif.imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL wrap_addr: got %h want 0", wif.imem_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    mem_lat = 3; mem_rand = 1'b0;
    do_reset();
    mem_lat = 1;
    release_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); mem_auto = 1'b0; man_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0; man_valid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    n_cmp++;
    if (mif.imem_req_o !== 1'b0 || ifid_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst: got req=%0b v=%0b want 0/0", mif.imem_req_o, ifid_valid);
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (perf_f !== 32'h0 || perf_b !== 32'h0) begin
      n_bad++; $display("FAIL perf_rst: got %h/%h want 0/0", perf_f, perf_b);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (ifid_valid !== 1'b0 || mif.imem_req_o !== 1'b1 || mif.imem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL late_valid: got v=%0b req=%0b addr=%h want 0/1/0", ifid_valid, mif.imem_req_o, mif.imem_addr_o);
    end
    @(negedge clk); man_valid = 1'b0; mem_auto = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge clk); #1;
      if (ifid_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || ifid_pc !== 32'h0 || ifid_inst !== mem_word(32'h0)) begin
      n_bad++; $display("FAIL post_rst_fetch: got seen=%0b pc=%h inst=%h want 1/0/%h", seen, ifid_pc, ifid_inst, mem_word(32'h0));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, p_pc, p_inst, p_pc4;
    logic        p_valid;
    int          delivered;
    mem_rand = 1'b1;
    do_reset(); release_reset();
    exp_pc = 32'h0; delivered = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      stall = ($urandom_range(99) < 25);
      flush = ($urandom_range(99) < 8);
      tgt   = $urandom;
      p_valid = ifid_valid; p_pc = ifid_pc; p_inst = ifid_inst; p_pc4 = ifid_pc4;
      @(posedge clk); #1;
      if (!ifid_valid) begin
        n_cmp++;
        if (ifid_inst !== NOP) begin n_bad++; $display("FAIL rnd_nop[%0d]: got %h want %h", n, ifid_inst, NOP); end
      end
      if (flush) begin
        n_cmp++;
        if (ifid_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_flush[%0d]: got v=%0b want 0", n, ifid_valid); end
        exp_pc = tgt & 32'hFFFF_FFFC;
      end else if (stall) begin
        n_cmp++;
        if (ifid_valid !== p_valid || (p_valid && (ifid_pc !== p_pc || ifid_inst !== p_inst || ifid_pc4 !== p_pc4))) begin
          n_bad++; $display("FAIL rnd_stall[%0d]: got v=%0b pc=%h want v=%0b pc=%h", n, ifid_valid, ifid_pc, p_valid, p_pc);
        end
      end else if (ifid_valid) begin
        n_cmp++;
        if (ifid_pc !== exp_pc || ifid_inst !== mem_word(exp_pc) || ifid_pc4 !== exp_pc + 32'd4) begin
          n_bad++; $display("FAIL rnd_stream[%0d]: got pc=%h inst=%h pc4=%h want pc=%h inst=%h pc4=%h", n,
                            ifid_pc, ifid_inst, ifid_pc4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    @(negedge clk); stall = 1'b0; flush = 1'b0;
    n_cmp++;
    if (delivered < 40) begin n_bad++; $display("FAIL rnd_progress: got %0d delivered want >= 40", delivered); end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; tgt = 32'h0;
    mem_auto = 1'b0; mem_rand = 1'b0; mem_lat = 1; man_valid = 1'b0; man_rdata = 32'h0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush_drain();
    test_flush_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
